// File: rtl/regfile_mp.sv
// Multi-read-port GPR file with entry 0 hardwired to zero, write-to-read bypass and a
// post-reset clearing sweep. Define REGFILE_SCOREBOARD_EN to add per-entry busy tracking.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
  output logic [NUM_RD*DATA_W-1:0] rdata_o,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic                     alloc_i,
  input  logic [ADDR_W-1:0]        alloc_addr_i,
`endif
  output logic                     ready_o,
  output logic [NUM_RD-1:0]        busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {INIT, RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ready_q;
  logic [DATA_W-1:0]   mem_q [1:DEPTH-1];
  logic                wr_en;

  // A write presented while reset is sampled is dropped.
  assign wr_en   = !rst && (state_q == RUN) && we_i && (waddr_i != '0);
  assign ready_o = ready_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (&cnt_q) begin
        state_q <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset branch; the INIT sweep clears it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      if (cnt_q != '0) mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_q;

  // Clear on write first, then set on alloc, so a same-cycle allocation wins.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      busy_q[cnt_q] <= 1'b0;
    end else if (!rst) begin
      if (we_i) busy_q[waddr_i] <= 1'b0;
      if (alloc_i && (alloc_addr_i != '0)) busy_q[alloc_addr_i] <= 1'b1;
    end
  end
`endif

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin : read_ports
    logic [ADDR_W-1:0] ra;
    rdata_o = '0;
    busy_o  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = raddr_i[k*ADDR_W +: ADDR_W];
      if ((state_q == RUN) && (ra != '0)) begin
        if (we_i && (waddr_i == ra)) begin
          rdata_o[k*DATA_W +: DATA_W] = wdata_i;
        end else begin
          rdata_o[k*DATA_W +: DATA_W] = mem_q[ra];
`ifdef REGFILE_SCOREBOARD_EN
          busy_o[k] = busy_q[ra];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vectors, reset/sweep corner cases and
// random traffic against an array-based reference model (REGFILE_SCOREBOARD_EN aware).
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR*AW-1:0]   raddr;
  logic [NR*DW-1:0]   rdata;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [DW-1:0]      wdata;
  logic               ready;
  logic [NR-1:0]      busy;
  logic               alloc;
  logic [AW-1:0]      alloc_addr;

  int n_checks = 0;
  int n_err    = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .raddr_i     (raddr),
    .rdata_o     (rdata),
    .we_i        (we),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
`ifdef REGFILE_SCOREBOARD_EN
    .alloc_i     (alloc),
    .alloc_addr_i(alloc_addr),
`endif
    .ready_o     (ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: reset zeroes everything instantly and then just counts DEPTH
  // cycles before the file becomes ready; nothing is visible before that.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  int            m_init_left;
  bit            m_ready;

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return '0;
    if (we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
`ifdef REGFILE_SCOREBOARD_EN
    if (!m_ready || a == 0) return 1'b0;
    if (we && waddr == a) return 1'b0;
    return m_busy[a];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
      m_init_left = DEPTH;
      m_ready     = 1'b0;
    end else if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) m_ready = 1'b1;
    end else begin
      if (we && waddr != 0) m_mem[waddr] = wdata;
      if (we) m_busy[waddr] = 1'b0;
      if (alloc && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0] a;
    for (int k = 0; k < NR; k++) begin
      a = raddr[k*AW +: AW];
      check($sformatf("rdata%0d[x%0d]", k, a), 64'(rdata[k*DW +: DW]), 64'(exp_rdata(a)));
      check($sformatf("busy%0d[x%0d]", k, a), 64'(busy[k]), 64'(exp_busy(a)));
    end
    check("ready", 64'(ready), 64'(m_ready));
  endtask

  // Inputs are driven at the falling edge; outputs are checked 1 time unit later.
  task automatic step();
    #1 check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_rd(input int a0, input int a1);
    logic [AW-1:0] r0, r1;
    r0 = AW'(a0);
    r1 = AW'(a1);
    raddr = {r1, r0};
  endtask

  // Counts cycles with ready low; optionally injects a write at sweep cycle 10.
  task automatic measure_sweep(input string name, input bit write_at_10);
    int low = 0;
    while (ready !== 1'b1 && low < 100) begin
      set_rd(low % DEPTH, DEPTH - 1 - (low % DEPTH));
      if (write_at_10 && low == 10) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hFF;
      end else begin
        we = 1'b0;
      end
      step();
      low++;
    end
    we = 1'b0;
    check(name, 64'(low), 64'(DEPTH));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] r0, r1;
    logic [DW-1:0] e0, e1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd0, 32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd7, 32'h11,       5'd7, 5'd8, 32'h11,       32'h0};
    vecs[5] = '{1'b1, 5'd7, 32'h22,       5'd7, 5'd8, 32'h22,       32'h0};
    vecs[6] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd8, 32'h22,       32'h0};
    vecs[7] = '{1'b1, 5'd8, 32'h33,       5'd7, 5'd8, 32'h22,       32'h33};
    vecs[8] = '{1'b0, 5'd0, 32'h0,        5'd8, 5'd31, 32'h33,      32'h0};

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    alloc = 1'b0; alloc_addr = '0;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b0;

    // Reset then idle: sweep length, INIT reads, ignored INIT write to x3.
    measure_sweep("init_sweep_len", 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(i, DEPTH - 1 - i);
      #1 check($sformatf("post_init_x%0d", i), 64'(rdata[DW-1:0]), 64'h0);
      step();
    end

    // Directed vectors in RUN.
    for (int v = 0; v < 9; v++) begin
      we = vecs[v].we; waddr = vecs[v].wa; wdata = vecs[v].wd;
      raddr = {vecs[v].r1, vecs[v].r0};
      #1;
      check($sformatf("vec%0d_port0", v), 64'(rdata[DW-1:0]), 64'(vecs[v].e0));
      check($sformatf("vec%0d_port1", v), 64'(rdata[2*DW-1:DW]), 64'(vecs[v].e1));
      step();
    end
    we = 1'b0;

    // Reset mid-RUN: x9 must be cleared by the new sweep.
    we = 1'b1; waddr = 5'd9; wdata = 32'hAA;
    step();
    we = 1'b0; set_rd(9, 0);
    #1 check("x9_before_reset", 64'(rdata[DW-1:0]), 64'hAA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    measure_sweep("rerun_sweep_len", 1'b0);
    set_rd(9, 9);
    #1 check("x9_after_reset", 64'(rdata[DW-1:0]), 64'h0);
    step();

`ifdef REGFILE_SCOREBOARD_EN
    alloc = 1'b1; alloc_addr = 5'd4; set_rd(4, 0);
    step();
    alloc = 1'b0;
    #1 check("busy_after_alloc", 64'(busy[0]), 64'h1);
    step();
    we = 1'b1; waddr = 5'd4; wdata = 32'h55;
    #1 check("busy_bypass_write", 64'(busy[0]), 64'h0);
    step();
    we = 1'b0;
    #1 check("busy_after_write", 64'(busy[0]), 64'h0);
    check("x4_after_write", 64'(rdata[DW-1:0]), 64'h55);
    step();
    alloc = 1'b1; alloc_addr = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'h66;
    step();
    alloc = 1'b0; we = 1'b0;
    #1 check("busy_alloc_wins", 64'(busy[0]), 64'h1);
    step();
`endif

    // Random traffic with occasional resets, biased towards a few addresses.
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      we         = $urandom_range(0, 1) == 1;
      waddr      = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wdata      = $urandom;
      alloc      = $urandom_range(0, 2) == 0;
      alloc_addr = AW'($urandom_range(0, 7));
      set_rd($urandom_range(0, 1) == 1 ? int'(waddr) : $urandom_range(0, 7),
             $urandom_range(0, DEPTH - 1));
      step();
    end
    rst = 1'b0; we = 1'b0; alloc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised general-purpose register file for the RISC-V core; successor to the fixed 2-read/1-write GPR array.
- Configurable data width, address width and number of read ports. Entry 0 is hardwired to zero.
- Write-to-read bypass on every read port.
- Post-reset initialisation sweep clears every entry. `ready_o` stays low until the sweep completes.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- raddr_i  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rdata_o  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- we_i  input  1  write enable
- waddr_i  input  ADDR_W  write address
- wdata_i  input  DATA_W  write data
- ready_o  output  1  high when the init sweep is done and the file accepts writes
- busy_o  output  NUM_RD  per-read-port busy flag (scoreboard builds only, see below)

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, sampled on the `clk` rising edge.
- FSM states: INIT, RUN.
- rst=1 → next state INIT, sweep counter cnt=0, ready_o=0.
- INIT:
  - Each cycle, entry[cnt] <= 0 and cnt <= cnt+1.
  - When cnt == DEPTH-1, the clear still happens that cycle, then next state is RUN.
  - Sweep takes exactly DEPTH cycles; ready_o rises on the cycle after the last clear.
  - we_i is ignored in INIT: no write, no bypass.
  - All rdata_o lanes read 0 in INIT.
- RUN:
  - ready_o=1.
  - Write: we_i=1 and waddr_i!=0 → entry[waddr_i] <= wdata_i at the clock edge.
  - Writes to address 0 are discarded.
- Reads are combinational (0-cycle latency), per port k:
  - raddr==0 → 0
  - else we_i=1 and waddr_i==raddr → wdata_i (bypass, same-cycle)
  - else entry[raddr]
- Multiple read ports may address the same entry; each resolves independently with identical results.
- Reset asserted mid-INIT or mid-RUN: the sweep restarts from cnt=0 on the next cycle, and ready_o drops to 0 on the cycle after rst is sampled. Any write presented in the reset cycle is discarded.
- Entry 0 is never stored; the storage array may omit it. Sweeping index 0 is a no-op.
- No X propagates to rdata_o after reset, including for entries never written.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- When defined, extra inputs are added: alloc_i (1) and alloc_addr_i (ADDR_W). Internal busy[DEPTH] bits are kept.
- In RUN:
  - alloc_i=1 and alloc_addr_i!=0 → busy[alloc_addr_i] <= 1.
  - we_i=1 → busy[waddr_i] <= 0.
  - Same address allocated and written in the same cycle → busy ends at 1 (new producer wins).
- busy_o[k] = busy[raddr_k] combinationally. It is also forced to 0 when raddr_k==0, or when we_i=1 and waddr_i==raddr_k (the bypass makes the value available).
- All busy bits are cleared during INIT, one per sweep cycle along with the data. busy_o is 0 in INIT.
- When undefined: alloc ports, busy storage and logic are absent, and busy_o is tied to 0.

Test Plan:
- Reset then idle, DEPTH=32 → ready_o=0 for exactly 32 cycles after rst deasserts, then 1. All ports read 0 for addresses 0..31.
- RUN: write 0xDEADBEEF to x5, then read x5 on ports 0 and 1 next cycle → both 0xDEADBEEF. Write 0x1234 to x0 → x0 reads 0.
- Same-cycle bypass: entry x7=0x11, present we_i=1, waddr=7, wdata=0x22, raddr0=7 → rdata0=0x22 in that cycle. raddr1=8 is unaffected.
- Write during INIT: we_i=1, waddr=3, wdata=0xFF at sweep cycle 10 → after RUN, x3 reads 0.
- Reset mid-RUN: x9=0xAA, assert rst for 1 cycle → ready_o low for 32 cycles, then x9 reads 0.
- REGFILE_SCOREBOARD_EN:
  - alloc x4, then raddr0=4 → busy_o[0]=1.
  - Next cycle, write x4 with 0x55 → busy_o[0]=0 in that cycle via bypass, and stays 0 after.
  - Simultaneous alloc x4 and write x4 → busy stays 1.
